// File: rtl/convolution_coprocessor_mux_rr.sv
// N-channel registered selector with fixed-select or round-robin grant and a one-entry output register.
// Optional zero-pad injection is enabled by defining CONV_MUX_ZERO_PAD_EN.
module convolution_coprocessor_mux_rr #(
   parameter  int DATA_WIDTH = 6,
   parameter  int NUM_CH     = 4,
   localparam int SEL_WIDTH  = $clog2(NUM_CH)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
   input  logic [NUM_CH-1:0]            in_valid,
   output logic [NUM_CH-1:0]            in_ready,
   input  logic                         mode,
   input  logic [SEL_WIDTH-1:0]         sel,
   input  logic                         pad,
   output logic [DATA_WIDTH-1:0]        out_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [SEL_WIDTH-1:0]         out_ch,
   output logic                         sel_err
);

   logic [NUM_CH-1:0][DATA_WIDTH-1:0] lane_data;
   logic [NUM_CH-1:0]                 grant;
   logic [SEL_WIDTH-1:0]              win;
   logic [SEL_WIDTH-1:0]              ptr;
   logic                              load_en;
   logic                              pad_active;
   logic                              sel_ok;
   logic                              xfer;
   logic                              found;

   for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
      assign lane_data[k] = in_data[k*DATA_WIDTH +: DATA_WIDTH];
   end

`ifdef CONV_MUX_ZERO_PAD_EN
   assign pad_active = pad;
`else
   logic unused_pad;
   assign unused_pad = pad;
   assign pad_active = 1'b0;
`endif

   assign load_en = !out_valid | out_ready;
   assign sel_ok  = ({{(32-SEL_WIDTH){1'b0}}, sel} < 32'(NUM_CH));

   // Round-robin search begins one past the last winner, so ptr=NUM_CH-1 favours channel 0.
   always_comb begin
      int idx;
      grant = '0;
      win   = '0;
      found = 1'b0;
      idx   = 0;
      if (!mode) begin
         if (sel_ok && in_valid[sel]) begin
            grant[sel] = 1'b1;
            win        = sel;
         end
      end else begin
         for (int i = 1; i <= NUM_CH; i++) begin
            idx = (int'(ptr) + i) % NUM_CH;
            if (!found && in_valid[idx]) begin
               found      = 1'b1;
               grant[idx] = 1'b1;
               win        = SEL_WIDTH'(idx);
            end
         end
      end
   end

   assign in_ready = rst ? '0 : (grant & {NUM_CH{load_en & !pad_active}});
   assign xfer     = |(in_valid & in_ready);

   always_ff @(posedge clk) begin
      if (rst) begin
         out_data  <= '0;
         out_valid <= 1'b0;
         out_ch    <= '0;
         sel_err   <= 1'b0;
         ptr       <= SEL_WIDTH'(NUM_CH-1);
      end else begin
         if (!mode && !sel_ok)
            sel_err <= 1'b1;
         if (load_en) begin
            if (pad_active) begin
               out_data  <= '0;
               out_ch    <= '0;
               out_valid <= 1'b1;
            end else if (xfer) begin
               out_data  <= lane_data[win];
               out_ch    <= win;
               out_valid <= 1'b1;
               if (mode)
                  ptr <= win;
            end else begin
               out_valid <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_convolution_coprocessor_mux_rr.sv
// Directed bench: table of per-cycle vectors on a 4-channel instance, plus a hand-written
// sel_err sequence on a 3-channel instance. Pad expectations follow CONV_MUX_ZERO_PAD_EN.
module tb_convolution_coprocessor_mux_rr;

`ifdef CONV_MUX_ZERO_PAD_EN
   localparam bit PAD_EN = 1'b1;
`else
   localparam bit PAD_EN = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // 4-channel instance
   logic        rst, mode, pad, out_ready, out_valid, sel_err;
   logic [1:0]  sel, out_ch;
   logic [3:0]  in_valid, in_ready;
   logic [23:0] in_data;
   logic [5:0]  out_data;

   convolution_coprocessor_mux_rr #(.DATA_WIDTH(6), .NUM_CH(4)) dut4 (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .mode(mode), .sel(sel), .pad(pad), .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .out_ch(out_ch), .sel_err(sel_err));

   // 3-channel instance, used where sel can exceed the channel count
   logic        rst3, mode3, out_valid3, sel_err3;
   logic [1:0]  sel3, out_ch3;
   logic [2:0]  in_valid3, in_ready3;
   logic [17:0] in_data3;
   logic [5:0]  out_data3;

   convolution_coprocessor_mux_rr #(.DATA_WIDTH(6), .NUM_CH(3)) dut3 (
      .clk(clk), .rst(rst3), .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
      .mode(mode3), .sel(sel3), .pad(1'b0), .out_data(out_data3), .out_valid(out_valid3),
      .out_ready(1'b1), .out_ch(out_ch3), .sel_err(sel_err3));

   typedef struct {
      logic       rst, mode;
      logic [1:0] sel;
      logic [3:0] vld;
      logic       ordy, pad;
      logic [3:0] e_rdy;
      logic       e_ov;
      logic [5:0] e_od;
      logic [1:0] e_ch;
   } vec_t;

   vec_t tv[23];
   int   n_vec = 0;
   int   n_bad = 0;

   task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s [%0d]: got %0h, expected %0h", name, idx, act, exp);
      end
   endtask

   function automatic vec_t mk(logic r, logic m, logic [1:0] s, logic [3:0] v, logic o, logic p,
                               logic [3:0] er, logic eov, logic [5:0] eod, logic [1:0] ech);
      vec_t t;
      t.rst = r; t.mode = m; t.sel = s; t.vld = v; t.ordy = o; t.pad = p;
      t.e_rdy = er; t.e_ov = eov; t.e_od = eod; t.e_ch = ech;
      return t;
   endfunction

   initial begin
      // ch3=63, ch2=42 (6'b101010), ch1=5, ch0=17
      in_data  = {6'd63, 6'd42, 6'd5, 6'd17};
      in_data3 = {6'd33, 6'd20, 6'd9};
      //           rst mode sel  valid    ordy pad  e_rdy    ov  od      ch
      tv[0]  = mk(1, 0, 2'd0, 4'b1111, 1, 0, 4'b0000, 0, 6'd0,  2'd0); // reset, all valid
      tv[1]  = mk(1, 0, 2'd0, 4'b1111, 1, 0, 4'b0000, 0, 6'd0,  2'd0);
      tv[2]  = mk(0, 0, 2'd2, 4'b1111, 1, 0, 4'b0100, 1, 6'd42, 2'd2); // fixed sel=2
      tv[3]  = mk(0, 1, 2'd2, 4'b1111, 1, 0, 4'b0001, 1, 6'd17, 2'd0); // RR all valid
      tv[4]  = mk(0, 1, 2'd2, 4'b1111, 1, 0, 4'b0010, 1, 6'd5,  2'd1);
      tv[5]  = mk(0, 1, 2'd2, 4'b1111, 1, 0, 4'b0100, 1, 6'd42, 2'd2);
      tv[6]  = mk(0, 1, 2'd2, 4'b1111, 1, 0, 4'b1000, 1, 6'd63, 2'd3);
      tv[7]  = mk(0, 1, 2'd2, 4'b1111, 1, 0, 4'b0001, 1, 6'd17, 2'd0); // wrap
      tv[8]  = mk(0, 1, 2'd2, 4'b1010, 1, 0, 4'b0010, 1, 6'd5,  2'd1); // ch1/ch3 only
      tv[9]  = mk(0, 1, 2'd2, 4'b1010, 1, 0, 4'b1000, 1, 6'd63, 2'd3);
      tv[10] = mk(0, 1, 2'd2, 4'b1010, 1, 0, 4'b0010, 1, 6'd5,  2'd1);
      tv[11] = mk(0, 1, 2'd2, 4'b1010, 1, 0, 4'b1000, 1, 6'd63, 2'd3);
      tv[12] = mk(0, 1, 2'd2, 4'b1111, 0, 0, 4'b0000, 1, 6'd63, 2'd3); // backpressure x3
      tv[13] = mk(0, 1, 2'd2, 4'b1111, 0, 0, 4'b0000, 1, 6'd63, 2'd3);
      tv[14] = mk(0, 1, 2'd2, 4'b1111, 0, 0, 4'b0000, 1, 6'd63, 2'd3);
      tv[15] = mk(0, 1, 2'd2, 4'b1111, 1, 0, 4'b0001, 1, 6'd17, 2'd0); // drain + reload
      tv[16] = mk(0, 1, 2'd2, 4'b0000, 1, 0, 4'b0000, 0, 6'd17, 2'd0); // idle, data holds
      tv[17] = mk(0, 0, 2'd1, 4'b0001, 1, 0, 4'b0000, 0, 6'd17, 2'd0); // sel ch not valid
      tv[18] = mk(0, 0, 2'd1, 4'b0010, 0, 0, 4'b0010, 1, 6'd5,  2'd1); // empty reg loads w/o out_ready
      tv[19] = mk(0, 0, 2'd1, 4'b0010, 0, 0, 4'b0000, 1, 6'd5,  2'd1);
      tv[20] = mk(1, 0, 2'd1, 4'b0010, 0, 0, 4'b0000, 0, 6'd0,  2'd0); // reset mid-hold
      tv[21] = mk(0, 0, 2'd0, 4'b0001, 1, 1, PAD_EN ? 4'b0000 : 4'b0001, 1,
                  PAD_EN ? 6'd0 : 6'd17, 2'd0);                        // pad request
      tv[22] = mk(0, 0, 2'd0, 4'b0001, 1, 0, 4'b0001, 1, 6'd17, 2'd0);

      rst3 = 1'b1; mode3 = 1'b0; sel3 = 2'd0; in_valid3 = 3'b000;

      for (int i = 0; i < 23; i++) begin
         rst = tv[i].rst; mode = tv[i].mode; sel = tv[i].sel; in_valid = tv[i].vld;
         out_ready = tv[i].ordy; pad = tv[i].pad;
         #1;
         if (i > 0) chk("in_ready", i, 32'(in_ready), 32'(tv[i].e_rdy));
         @(posedge clk); #1;
         chk("out_valid", i, 32'(out_valid), 32'(tv[i].e_ov));
         chk("out_data",  i, 32'(out_data),  32'(tv[i].e_od));
         chk("out_ch",    i, 32'(out_ch),    32'(tv[i].e_ch));
      end
      chk("sel_err4", 0, 32'(sel_err), 32'd0);

      // sel_err sequence on the 3-channel instance
      rst3 = 1'b1; in_valid3 = 3'b111;
      repeat (2) @(posedge clk);
      #1;
      chk("rdy3_rst",   0, 32'(in_ready3), 32'd0);
      chk("err3_rst",   0, 32'(sel_err3),  32'd0);
      rst3 = 1'b0; mode3 = 1'b0; sel3 = 2'd3;
      #1;
      chk("rdy3_oor",   0, 32'(in_ready3), 32'd0);
      @(posedge clk); #1;
      chk("err3_set",   0, 32'(sel_err3),  32'd1);
      chk("ov3_nogrnt", 0, 32'(out_valid3), 32'd0);
      sel3 = 2'd0;
      #1;
      chk("rdy3_sel0",  0, 32'(in_ready3), 32'b001);
      @(posedge clk); #1;
      chk("err3_stick", 0, 32'(sel_err3),  32'd1);
      chk("od3_sel0",   0, 32'(out_data3), 32'd9);
      rst3 = 1'b1;
      @(posedge clk); #1;
      chk("err3_clr",   0, 32'(sel_err3),  32'd0);
      rst3 = 1'b0; mode3 = 1'b1; sel3 = 2'd3; in_valid3 = 3'b110;
      @(posedge clk); #1;
      chk("err3_rrmode", 0, 32'(sel_err3), 32'd0);
      chk("ch3_rr",      0, 32'(out_ch3),  32'd1);
      chk("od3_rr",      0, 32'(out_data3), 32'd20);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
